// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared fetch-stage defaults and FSM state encodings
package instr_fetch_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int RESET_PC_DEF = 0;
  localparam logic [1:0] FS_IDLE = 2'd0;
  localparam logic [1:0] FS_REQ = 2'd1;
  localparam logic [1:0] FS_VALID = 2'd2;
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: holds the PC, fetches one byte per request/ack, hands it to the decoder via valid/ready
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              increment_pc,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc
);
  logic [1:0] state, state_n;
  logic [ADDR_W-1:0] pc_n, pending_addr, pending_addr_n;
  logic [7:0] instr_n;
  logic valid_n, jump_pending, jump_pending_n;
  assign mem_req = state == FS_REQ;
  assign mem_addr = pc;
  // A jump seen while a request is open is parked until the ack closes it; the ack data is then discarded
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = instr;
    valid_n = instr_valid;
    jump_pending_n = jump_pending;
    pending_addr_n = pending_addr;
    if (state == FS_IDLE) begin
      state_n = FS_REQ;
    end else if (state == FS_REQ) begin
      if (mem_ack) begin
        jump_pending_n = 1'b0;
        if (jump_en || jump_pending) begin
          pc_n = jump_en ? jump_addr : pending_addr;
        end else begin
          instr_n = mem_rdata;
          valid_n = 1'b1;
          state_n = FS_VALID;
        end
      end else if (jump_en) begin
        jump_pending_n = 1'b1;
        pending_addr_n = jump_addr;
      end
    end else if (state == FS_VALID) begin
      if (jump_en || instr_ready) begin
        valid_n = 1'b0;
        state_n = FS_REQ;
        pc_n = jump_en ? jump_addr : pc + ADDR_W'(increment_pc);
      end
    end else begin
      state_n = FS_IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FS_IDLE;
      pc <= RESET_PC;
      instr <= 8'h00;
      instr_valid <= 1'b0;
      jump_pending <= 1'b0;
      pending_addr <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      instr <= instr_n;
      instr_valid <= valid_n;
      jump_pending <= jump_pending_n;
      pending_addr <= pending_addr_n;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random stimulus checked against a transaction-level fetch model
module tb_instr_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_req, mem_ack = 1'b0, instr_valid, instr_ready = 1'b0, increment_pc = 1'b1, jump_en = 1'b0;
  logic [7:0] mem_addr, mem_rdata = 8'h00, instr, jump_addr = 8'h00, pc;
  int n_chk = 0, n_fail = 0;
  bit m_started, m_valid, m_pend;
  int m_pc, m_instr, m_pend_addr;

  instr_fetch dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .increment_pc(increment_pc), .jump_en(jump_en), .jump_addr(jump_addr), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0;
    m_valid = 0;
    m_pend = 0;
    m_pc = 0;
    m_instr = 0;
    m_pend_addr = 0;
  endtask

  // Fetch behaviour per clock: wait one cycle, then alternate "requesting" and "holding a byte"
  task automatic model_edge();
    if (reset) model_reset();
    else if (!m_started) m_started = 1;
    else if (!m_valid) begin
      if (mem_ack) begin
        if (jump_en) m_pc = jump_addr;
        else if (m_pend) m_pc = m_pend_addr;
        else begin
          m_instr = mem_rdata;
          m_valid = 1;
        end
        m_pend = 0;
      end else if (jump_en) begin
        m_pend = 1;
        m_pend_addr = jump_addr;
      end
    end else if (jump_en) begin
      m_pc = jump_addr;
      m_valid = 0;
    end else if (instr_ready) begin
      m_pc = (m_pc + (increment_pc ? 1 : 0)) % 256;
      m_valid = 0;
    end
  endtask

  task automatic compare();
    chk("model mem_req", int'(mem_req), int'(m_started && !m_valid));
    chk("model instr_valid", int'(instr_valid), int'(m_valid));
    chk("model pc", int'(pc), m_pc);
    chk("model mem_addr", int'(mem_addr), m_pc);
    if (m_valid) chk("model instr", int'(instr), m_instr);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset pc", int'(pc), 0);
    chk("reset mem_req", int'(mem_req), 0);
    chk("reset instr_valid", int'(instr_valid), 0);
    chk("reset instr", int'(instr), 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("first req", int'(mem_req), 1);
    chk("first addr", int'(mem_addr), 0);
    mem_ack = 1'b1; mem_rdata = 8'h08;
    step();
    chk("instr 08 valid", int'(instr_valid), 1);
    chk("instr 08", int'(instr), 8'h08);
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp instr", int'(instr), 8'h08);
      chk("bp valid", int'(instr_valid), 1);
      chk("bp pc", int'(pc), 0);
      chk("bp mem_req", int'(mem_req), 0);
    end
    instr_ready = 1'b1; increment_pc = 1'b1;
    step();
    chk("second addr", int'(mem_addr), 1);
    chk("second req", int'(mem_req), 1);
    instr_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h11;
    step();
    chk("instr 11", int'(instr), 8'h11);
    mem_ack = 1'b0; jump_en = 1'b1; jump_addr = 8'h05;
    step();
    jump_en = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h55;
    step();
    mem_ack = 1'b0; instr_ready = 1'b1; increment_pc = 1'b0;
    step();
    chk("hold addr", int'(mem_addr), 5);
    instr_ready = 1'b0; increment_pc = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h01;
    step();
    mem_ack = 1'b0; jump_en = 1'b1; jump_addr = 8'hFF;
    step();
    chk("jump ff", int'(mem_addr), 8'hFF);
    jump_en = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h02;
    step();
    mem_ack = 1'b0; instr_ready = 1'b1;
    step();
    chk("wrap addr", int'(mem_addr), 0);
    instr_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h03;
    step();
    mem_ack = 1'b0; jump_en = 1'b1; jump_addr = 8'h03;
    step();
    jump_addr = 8'h40;
    step();
    chk("wait addr 1", int'(mem_addr), 3);
    jump_addr = 8'h50;
    step();
    chk("wait addr 2", int'(mem_addr), 3);
    jump_en = 1'b0;
    step();
    chk("wait addr 3", int'(mem_addr), 3);
    mem_ack = 1'b1; mem_rdata = 8'hAA;
    step();
    chk("AA dropped", int'(instr_valid), 0);
    chk("redirect addr", int'(mem_addr), 8'h50);
    chk("redirect req", int'(mem_req), 1);
    mem_rdata = 8'h77;
    step();
    chk("instr 77", int'(instr), 8'h77);
    mem_ack = 1'b0; instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 8'h20;
    step();
    chk("valid jump drop", int'(instr_valid), 0);
    chk("valid jump pc", int'(pc), 8'h20);
    instr_ready = 1'b0; jump_en = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    chk("async pc", int'(pc), 0);
    chk("async mem_req", int'(mem_req), 0);
    chk("async valid", int'(instr_valid), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      mem_ack = $urandom_range(0, 1) == 1;
      mem_rdata = 8'($urandom);
      instr_ready = $urandom_range(0, 9) < 6;
      increment_pc = $urandom_range(0, 3) != 0;
      jump_en = $urandom_range(0, 9) == 0;
      jump_addr = 8'($urandom);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
